// File: rtl/product_bcd_converter.sv
// Captures the multiplier product on a done rising edge and converts it to
// packed BCD with a bit-serial double-dabble engine (one bit per clock).
module product_bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      product,
  input  logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    scratch_adj;
  logic [CW-1:0]    count;
  logic             done_q;
  logic             capture;

  assign capture = done & ~done_q;

  // Add-3 on every digit >= 5, evaluated in parallel on the pre-shift value.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      count     <= '0;
      done_q    <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_q    <= done;
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            bin     <= product;
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin} <= {scratch_adj[BW-2:0], bin, 1'b0};
          count          <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A rising edge that arrives mid-conversion is dropped and flagged.
      if (capture && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and random checks of product_bcd_converter with a queue scoreboard
// filled at each capture and drained on every bcd_valid pulse.
module tb_product_bcd_converter;

  logic        clk;
  logic        rst;
  logic [15:0] product;
  logic        done;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        overrun;

  int checks;
  int failures;
  int valid_cnt;
  int ovr_cnt;
  logic [19:0] exp_q[$];

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk),
    .rst(rst),
    .product(product),
    .done(done),
    .bcd(bcd),
    .bcd_valid(bcd_valid),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digit-by-digit division, independent of shift-add-3.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every valid pulse must match the oldest captured value.
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (bcd_valid) begin
      logic ok;
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {12'd0, bcd}, 32'hFFFF_FFFF);
      end else begin
        chk("bcd", {12'd0, bcd}, {12'd0, exp_q.pop_front()});
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
      chk("nibble_le9", {31'd0, ok}, 32'd1);
    end
  end

  initial begin
    int v0;
    int o0;
    checks    = 0;
    failures  = 0;
    valid_cnt = 0;
    ovr_cnt   = 0;
    rst       = 1'b0;
    done      = 1'b0;
    product   = '0;
    repeat (3) tick();
    chk("rst_bcd", {12'd0, bcd}, 32'd0);
    chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    tick();

    // Zero product: busy for 17 cycles, valid 17 edges after load.
    product = 16'd0;
    done    = 1'b1;
    tick();
    exp_q.push_back(to_bcd(0));
    chk("t1_busy_load", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t1_busy_shift", {31'd0, busy}, 32'd1);
      chk("t1_novalid_shift", {31'd0, bcd_valid}, 32'd0);
    end
    tick();
    chk("t1_valid_L17", {31'd0, bcd_valid}, 32'd1);
    chk("t1_busy_L17", {31'd0, busy}, 32'd0);
    chk("t1_bcd", {12'd0, bcd}, 32'h0_0000);
    done = 1'b0;
    tick();
    chk("t1_valid_pulse_end", {31'd0, bcd_valid}, 32'd0);

    // 65025 with done held 40 cycles: single capture, no overrun.
    v0 = valid_cnt;
    o0 = ovr_cnt;
    product = 16'd65025;
    done    = 1'b1;
    tick();
    exp_q.push_back(to_bcd(65025));
    product = 16'h1234;
    repeat (39) tick();
    done = 1'b0;
    tick();
    chk("t2_one_valid", valid_cnt - v0, 32'd1);
    chk("t2_no_overrun", ovr_cnt - o0, 32'd0);
    chk("t2_bcd_hold", {12'd0, bcd}, 32'h6_5025);

    // Back-to-back: second capture accepted on L+18.
    product = 16'd12345;
    done    = 1'b1;
    tick();
    exp_q.push_back(to_bcd(12345));
    done    = 1'b0;
    product = 16'd65535;
    repeat (16) tick();
    tick();
    chk("t3_first_valid", {31'd0, bcd_valid}, 32'd1);
    chk("t3_first_bcd", {12'd0, bcd}, 32'h1_2345);
    done = 1'b1;
    tick();
    exp_q.push_back(to_bcd(65535));
    chk("t3_second_accept", {31'd0, busy}, 32'd1);
    chk("t3_no_overrun", {31'd0, overrun}, 32'd0);
    done = 1'b0;
    repeat (16) tick();
    chk("t3_second_early", {31'd0, bcd_valid}, 32'd0);
    tick();
    chk("t3_second_valid_18", {31'd0, bcd_valid}, 32'd1);
    chk("t3_second_bcd", {12'd0, bcd}, 32'h6_5535);
    tick();

    // Second rising edge 5 cycles after load is dropped with overrun.
    v0 = valid_cnt;
    o0 = ovr_cnt;
    product = 16'd9999;
    done    = 1'b1;
    tick();
    exp_q.push_back(to_bcd(9999));
    done = 1'b0;
    repeat (4) tick();
    product = 16'd1;
    done    = 1'b1;
    tick();
    chk("t4_overrun_pulse", {31'd0, overrun}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    done = 1'b0;
    tick();
    chk("t4_overrun_clear", {31'd0, overrun}, 32'd0);
    repeat (20) tick();
    chk("t4_one_overrun", ovr_cnt - o0, 32'd1);
    chk("t4_one_valid", valid_cnt - v0, 32'd1);
    chk("t4_bcd", {12'd0, bcd}, 32'h0_9999);

    // Asynchronous reset 8 cycles into a conversion aborts it.
    v0 = valid_cnt;
    product = 16'd4096;
    done    = 1'b1;
    tick();
    done = 1'b0;
    repeat (8) tick();
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_bcd", {12'd0, bcd}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_valid", {31'd0, bcd_valid}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("t5_no_valid_aborted", valid_cnt - v0, 32'd0);
    done = 1'b1;
    tick();
    exp_q.push_back(to_bcd(4096));
    done = 1'b0;
    repeat (17) tick();
    chk("t5_bcd_after", {12'd0, bcd}, 32'h0_4096);
    tick();

    // Random multiplier products, back-to-back at the maximum rate.
    v0 = valid_cnt;
    for (int n = 0; n < 500; n++) begin
      int unsigned mcd;
      int unsigned mlt;
      mcd     = $urandom_range(0, 255);
      mlt     = $urandom_range(0, 255);
      product = 16'(mcd * mlt);
      done    = 1'b1;
      tick();
      exp_q.push_back(to_bcd(mcd * mlt));
      done    = 1'b0;
      product = 16'($urandom);
      repeat (17) tick();
    end
    repeat (3) tick();
    chk("t6_valid_count", valid_cnt - v0, 32'd500);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
